// File: rtl/fir_param_if.sv
// Sample, coefficient-load and filtered-output signals of one FIR channel.
// The master drives samples and coefficient writes; the filter (slave) drives the output.
interface fir_param_if #(
  parameter int DW = 8,
  parameter int CW = 10,
  parameter int OW = 18,
  parameter int AW = 3
) ();
  logic                 in_valid;
  logic [DW-1:0]        in_data;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_commit;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;
  logic                 out_sat;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, coef_commit,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, coef_commit,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_param.sv
// Transposed-form FIR with double-buffered coefficients, scaling and saturation.
// Output registered one cycle after each accepted sample; there is no backpressure, and idle cycles hold all state.
module fir_param #(
  parameter int NTAPS     = 7,
  parameter int DW        = 8,
  parameter int IN_SIGNED = 0,
  parameter int CW        = 10,
  parameter int OW        = 18,
  parameter int SHIFT     = 0,
  parameter int AW        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  fir_param_if.slave  bus
);
  // Wide enough for NTAPS full-precision products, so the sum can never overflow (assumes AC >= OW).
  localparam int AC = DW + 1 + CW + $clog2(NTAPS);
  localparam logic signed [AC-1:0] MAXV = {{(AC-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AC-1:0] MINV = {{(AC-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [CW-1:0] wa_q [NTAPS];
  logic signed [CW-1:0] ws_q [NTAPS];
  logic signed [CW-1:0] ws_d [NTAPS];
  logic signed [AC-1:0] p_q  [1:NTAPS-1];
  logic signed [AC-1:0] prod [NTAPS];

  logic signed [DW:0]   xe;
  logic signed [AC-1:0] xa;
  logic signed [AC-1:0] acc;
  logic signed [AC-1:0] s;
  logic signed [OW-1:0] out_data_d, out_data_q;
  logic                 out_sat_d, out_sat_q, out_valid_q;

  always_comb begin
    xe = (IN_SIGNED != 0) ? {bus.in_data[DW-1], bus.in_data} : {1'b0, bus.in_data};
    xa = AC'(xe);
    for (int k = 0; k < NTAPS; k++) begin
      prod[k] = xa * AC'(wa_q[k]);
    end
    acc = prod[0] + p_q[1];
    s   = acc >>> SHIFT;
    out_data_d = s[OW-1:0];
    out_sat_d  = 1'b0;
    if (s > MAXV) begin
      out_data_d = MAXV[OW-1:0];
      out_sat_d  = 1'b1;
    end else if (s < MINV) begin
      out_data_d = MINV[OW-1:0];
      out_sat_d  = 1'b1;
    end
  end

  // Addresses that match no tap fall through the loop and are dropped.
  always_comb begin
    ws_d = ws_q;
    for (int k = 0; k < NTAPS; k++) begin
      if (bus.coef_we && (bus.coef_addr == AW'(k))) begin
        ws_d[k] = bus.coef_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        wa_q[k] <= '0;
        ws_q[k] <= '0;
      end
      for (int k = 1; k < NTAPS; k++) begin
        p_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      ws_q <= ws_d;
      // A commit discards the in-flight partial sums even when a sample is accepted.
      if (bus.coef_commit) begin
        wa_q <= ws_d;
        for (int k = 1; k < NTAPS; k++) begin
          p_q[k] <= '0;
        end
      end else if (bus.in_valid) begin
        for (int k = 1; k < NTAPS - 1; k++) begin
          p_q[k] <= prod[k] + p_q[k+1];
        end
        p_q[NTAPS-1] <= prod[NTAPS-1];
      end
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_fir_param.sv
// Three filter instances (unsigned, unsigned with SHIFT=2, signed input) share one stimulus stream
// and are compared each cycle against a sum-of-products model, plus fixed expected-value vectors.
module tb_fir_param;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              coef_we = 1'b0;
  logic [2:0]        coef_addr = '0;
  logic signed [9:0] coef_data = '0;
  logic              coef_commit = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fir_param_if #(.DW(8), .CW(10), .OW(18), .AW(3)) if0 ();
  fir_param_if #(.DW(8), .CW(10), .OW(18), .AW(3)) if1 ();
  fir_param_if #(.DW(8), .CW(10), .OW(18), .AW(3)) if2 ();

  assign if0.in_valid = in_valid;    assign if1.in_valid = in_valid;    assign if2.in_valid = in_valid;
  assign if0.in_data = in_data;      assign if1.in_data = in_data;      assign if2.in_data = in_data;
  assign if0.coef_we = coef_we;      assign if1.coef_we = coef_we;      assign if2.coef_we = coef_we;
  assign if0.coef_addr = coef_addr;  assign if1.coef_addr = coef_addr;  assign if2.coef_addr = coef_addr;
  assign if0.coef_data = coef_data;  assign if1.coef_data = coef_data;  assign if2.coef_data = coef_data;
  assign if0.coef_commit = coef_commit;
  assign if1.coef_commit = coef_commit;
  assign if2.coef_commit = coef_commit;

  fir_param #(.NTAPS(7), .DW(8), .IN_SIGNED(0), .CW(10), .OW(18), .SHIFT(0), .AW(3))
    u_uns (.clk(clk), .rst_n(rst_n), .bus(if0));
  fir_param #(.NTAPS(7), .DW(8), .IN_SIGNED(0), .CW(10), .OW(18), .SHIFT(2), .AW(3))
    u_shf (.clk(clk), .rst_n(rst_n), .bus(if1));
  fir_param #(.NTAPS(7), .DW(8), .IN_SIGNED(1), .CW(10), .OW(18), .SHIFT(0), .AW(3))
    u_sgn (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic               ov [3];
  logic signed [17:0] od [3];
  logic               os [3];
  assign ov[0] = if0.out_valid; assign od[0] = if0.out_data; assign os[0] = if0.out_sat;
  assign ov[1] = if1.out_valid; assign od[1] = if1.out_data; assign os[1] = if1.out_sat;
  assign ov[2] = if2.out_valid; assign od[2] = if2.out_data; assign os[2] = if2.out_sat;

  // Reference model: active/shadow weights plus the samples accepted since the last flush.
  int         wa_m [7];
  int         ws_m [7];
  logic [7:0] hist [$];
  logic       exp_vld;
  longint     exp_dat [3];
  logic       exp_sat [3];

  int w_tab [7] = '{234, 465, 298, -345, 463, -345, 321};

  typedef struct {
    logic [7:0] x;
    int         dat;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint xval(input logic [7:0] b, input bit sgn);
    return sgn ? longint'($signed(b)) : longint'(b);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 7; k++) begin
      wa_m[k] = 0;
      ws_m[k] = 0;
    end
    hist.delete();
    exp_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_dat[i] = 0;
      exp_sat[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("inst%0d out_valid", i), longint'(ov[i]), longint'(exp_vld));
      chk($sformatf("inst%0d out_data", i), longint'(od[i]), exp_dat[i]);
      if (exp_vld) chk($sformatf("inst%0d out_sat", i), longint'(os[i]), longint'(exp_sat[i]));
    end
  endtask

  // One clock cycle: update the model from the driven inputs, clock, compare, clear the strobes.
  task automatic step();
    int     ws_n [7];
    longint acc, s;
    ws_n = ws_m;
    if (coef_we && coef_addr < 3'd7) ws_n[coef_addr] = int'(coef_data);
    exp_vld = in_valid;
    if (in_valid) begin
      hist.push_front(in_data);
      if (hist.size() > 7) void'(hist.pop_back());
      for (int i = 0; i < 3; i++) begin
        acc = 0;
        for (int k = 0; k < hist.size(); k++) acc += longint'(wa_m[k]) * xval(hist[k], i == 2);
        s = acc >>> ((i == 1) ? 2 : 0);
        exp_sat[i] = 1'b1;
        if (s > 131071) exp_dat[i] = 131071;
        else if (s < -131072) exp_dat[i] = -131072;
        else begin
          exp_dat[i] = s;
          exp_sat[i] = 1'b0;
        end
      end
    end
    if (coef_commit) begin
      wa_m = ws_n;
      hist.delete();
    end
    ws_m = ws_n;
    @(posedge clk);
    #1;
    check_all();
    in_valid = 1'b0;
    coef_we = 1'b0;
    coef_commit = 1'b0;
  endtask

  task automatic feed(input logic [7:0] x);
    in_valid = 1'b1;
    in_data = x;
    step();
  endtask

  task automatic wcoef(input logic [2:0] a, input int w);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = 10'(w);
    step();
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    step();
  endtask

  task automatic load_tab();
    for (int k = 0; k < 7; k++) wcoef(3'(k), w_tab[k]);
    commit();
  endtask

  initial begin
    model_reset();
    tv[0] = '{8'd1, 234};  tv[1] = '{8'd0, 465};  tv[2] = '{8'd0, 298};  tv[3] = '{8'd0, -345};
    tv[4] = '{8'd0, 463};  tv[5] = '{8'd0, -345}; tv[6] = '{8'd0, 321};  tv[7] = '{8'd0, 0};

    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse response, back-to-back samples
    load_tab();
    for (int i = 0; i < 8; i++) begin
      feed(tv[i].x);
      chk($sformatf("impulse[%0d] data", i), longint'(od[0]), longint'(tv[i].dat));
      chk($sformatf("impulse[%0d] sat", i), longint'(os[0]), 0);
    end

    // Constant full-scale input: saturates unscaled, fits after SHIFT=2
    commit();
    for (int i = 0; i < 7; i++) feed(8'd255);
    chk("dc255 shift0 data", longint'(od[0]), 131071);
    chk("dc255 shift0 sat", longint'(os[0]), 1);
    chk("dc255 shift2 data", longint'(od[1]), 69551);
    chk("dc255 shift2 sat", longint'(os[1]), 0);

    // Impulse with two idle cycles between samples
    commit();
    for (int i = 0; i < 8; i++) begin
      feed(tv[i].x);
      chk($sformatf("gap[%0d] pulse", i), longint'(ov[0]), 1);
      chk($sformatf("gap[%0d] data", i), longint'(od[0]), longint'(tv[i].dat));
      repeat (2) begin
        step();
        chk($sformatf("gap[%0d] idle", i), longint'(ov[0]), 0);
        chk($sformatf("gap[%0d] hold", i), longint'(od[0]), longint'(tv[i].dat));
      end
    end

    // Shadow writes are invisible until commit; commit with a sample uses the old weights
    commit();
    feed(8'd3);
    chk("swap pre", longint'(od[0]), 702);
    wcoef(3'd0, 1);
    for (int k = 1; k < 7; k++) wcoef(3'(k), 0);
    feed(8'd2);
    chk("swap shadow only", longint'(od[0]), 1863);
    coef_commit = 1'b1;
    feed(8'd5);
    chk("swap commit sample", longint'(od[0]), 2994);
    feed(8'd7);
    chk("swap flushed", longint'(od[0]), 7);

    // Asynchronous reset mid-stream, then cleared coefficients
    load_tab();
    feed(8'd9);
    feed(8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    feed(8'd100);
    chk("post-reset data", longint'(od[0]), 0);
    chk("post-reset valid", longint'(ov[0]), 1);

    // Signed input and an out-of-range coefficient address
    wcoef(3'd0, -512);
    commit();
    feed(8'h80);
    chk("signed -512*-128", longint'(od[2]), 65536);
    chk("unsigned -512*128", longint'(od[0]), -65536);
    wcoef(3'd7, 100);
    commit();
    feed(8'h80);
    feed(8'h00);
    chk("addr7 ignored", longint'(od[2]), 0);

    // Randomised traffic with coefficient writes and commits
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(9) < 6);
      in_data = 8'($urandom);
      coef_we = ($urandom_range(3) == 0);
      coef_addr = 3'($urandom);
      coef_data = 10'($urandom);
      coef_commit = ($urandom_range(39) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
